// File: rtl/cam_capture_pkg.sv
// Shared types and helpers for the OV7670 RGB444 capture path.
package cam_capture_pkg;

    // Width of the frame-buffer write address (covers 640x480 = 307200 pixels).
    localparam int ADDR_W = 19;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_VBLANK = 2'd2,
        ST_ACTIVE = 2'd3
    } cap_state_t;

    // One frame-buffer pixel, packed as {R,G,B} with four bits each.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Number of pixels in a full frame, which is also the first illegal address.
    function automatic int frame_pixels(input int h, input int v);
        return h * v;
    endfunction

endpackage

// File: rtl/cam_pixel_packer.sv
// Folds two camera bytes into one RGB444 pixel and tracks the byte count of
// each HREF window.
//
// All outputs are combinational from the current inputs and the registered
// phase/latch/counter, so the parent can register a write on the same edge
// that samples the second byte of a pixel.
//
// Byte 0 of a pixel carries R in d[3:0] (d[7:4] is discarded); byte 1
// carries {G,B}. When en_i is low (outside the active window, or while VSYNC
// is high) all state is held at its line-start value, so a line can never
// begin mid-pixel and no line check fires for a line cut off by VSYNC.
module cam_pixel_packer
    import cam_capture_pkg::*;
#(
    parameter int H_PIXELS = 640
) (
    input  logic       pclk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       href_i,
    input  logic [7:0] d_i,
    output logic       pix_valid_o,
    output rgb444_t    pix_o,
    output logic       line_end_o,
    output logic       line_bad_o
);

    // One spare bit so overlong lines saturate above the legal count.
    localparam int BCNT_W = $clog2(2 * H_PIXELS + 1) + 1;
    localparam logic [BCNT_W-1:0] LINE_BYTES = BCNT_W'(2 * H_PIXELS);
    localparam logic [BCNT_W-1:0] BCNT_MAX   = '1;

    logic              phase_q, phase_d;
    logic [3:0]        r_q, r_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              href_q, href_d;

    // Byte-phase sequencing, R latch, line byte counting and line-end detection.
    always_comb begin
        phase_d     = phase_q;
        r_d         = r_q;
        bcnt_d      = bcnt_q;
        href_d      = 1'b0;
        pix_valid_o = 1'b0;
        pix_o       = '0;
        line_end_o  = 1'b0;
        line_bad_o  = 1'b0;

        if (en_i) begin
            href_d = href_i;
            if (href_i) begin
                phase_d = ~phase_q;
                if (bcnt_q != BCNT_MAX) begin
                    bcnt_d = bcnt_q + 1'b1;
                end
                if (!phase_q) begin
                    r_d = d_i[3:0];
                end else begin
                    pix_valid_o = 1'b1;
                    pix_o       = '{r: r_q, g: d_i[7:4], b: d_i[3:0]};
                end
            end else begin
                // Any trailing half pixel is dropped here by clearing the phase.
                phase_d = 1'b0;
                bcnt_d  = '0;
                if (href_q) begin
                    line_end_o = 1'b1;
                    line_bad_o = (bcnt_q != LINE_BYTES);
                end
            end
        end else begin
            phase_d = 1'b0;
            bcnt_d  = '0;
        end
    end

    // Packer state registers.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= 1'b0;
            r_q     <= '0;
            bcnt_q  <= '0;
            href_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            r_q     <= r_d;
            bcnt_q  <= bcnt_d;
            href_q  <= href_d;
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture into the frame BRAM write port.
//
// The FSM only enters ACTIVE after seeing a complete VSYNC pulse (high then
// low), so capture always starts at a frame boundary. Pixels are written at
// consecutive addresses from 0; anything beyond the frame budget is dropped
// and flagged in overflow. Lines whose HREF window is not exactly
// 2*H_PIXELS bytes set line_err. Both flags are sticky until reset or an
// accepted start.
//
// Write port handshake: we is a single-cycle strobe with no back-pressure;
// addr/dout are valid in exactly the cycle we is high and hold their last
// values otherwise. Because each pixel takes two bytes, we is never high on
// two consecutive cycles.
module ov7670_capture
    import cam_capture_pkg::*;
#(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int CONTINUOUS = 1
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              frame_done,
    output logic              busy,
    output logic              line_err,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(frame_pixels(H_PIXELS, V_LINES));
    localparam int                LCNT_W    = $clog2(V_LINES + 1);
    localparam logic [LCNT_W-1:0] LINES_MAX = LCNT_W'(V_LINES);

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       dout_q, dout_d;
    logic              fd_q, fd_d;
    logic              lerr_q, lerr_d;
    logic              ovf_q, ovf_d;

    logic    pk_en;
    logic    pix_valid;
    rgb444_t pix;
    logic    line_end;
    logic    line_bad;

    // VSYNC takes priority over HREF in ACTIVE, so the packer is frozen
    // whenever VSYNC is high.
    assign pk_en = (state_q == ST_ACTIVE) && !vsync;

    cam_pixel_packer #(
        .H_PIXELS (H_PIXELS)
    ) u_packer (
        .pclk_i      (pclk),
        .rst_n_i     (rst_n),
        .en_i        (pk_en),
        .href_i      (href),
        .d_i         (d),
        .pix_valid_o (pix_valid),
        .pix_o       (pix),
        .line_end_o  (line_end),
        .line_bad_o  (line_bad)
    );

    // Frame FSM, address/line counters, write strobe and sticky status flags.
    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
        fd_d       = 1'b0;
        lerr_d     = lerr_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lerr_d = 1'b0;
                    ovf_d  = 1'b0;
                end
                if ((CONTINUOUS != 0) || start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (vsync) begin
                    state_d = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (!vsync) begin
                    state_d    = ST_ACTIVE;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (vsync) begin
                    fd_d    = 1'b1;
                    state_d = (CONTINUOUS != 0) ? ST_VBLANK : ST_IDLE;
                end else begin
                    if (pix_valid) begin
                        if (pix_cnt_q != FRAME_PIX) begin
                            we_d      = 1'b1;
                            addr_d    = pix_cnt_q;
                            dout_d    = pix;
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (line_end) begin
                        if (line_bad) begin
                            lerr_d = 1'b1;
                        end
                        // Line counter saturates at V_LINES; any further line
                        // is outside the frame.
                        if (line_cnt_q >= LINES_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset returns every output to zero.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
            fd_q       <= 1'b0;
            lerr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            fd_q       <= fd_d;
            lerr_q     <= lerr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign we         = we_q;
    assign addr       = addr_q;
    assign dout       = dout_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != ST_IDLE);
    assign line_err   = lerr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture using a reduced 4x3 frame. Two instances share the
// camera bus: u_cont re-arms every frame, u_one captures one frame per start.
// Stimulus pushes each expected {addr,dout} into a per-instance queue; a
// monitor on the falling edge pops and compares on every write strobe.
module tb_ov7670_capture;
    import cam_capture_pkg::*;

    localparam int H          = 4;
    localparam int V          = 3;
    localparam int FRAME      = H * V;
    localparam int LINE_BYTES = 2 * H;
    localparam int EW         = ADDR_W + 12;

    // ---------------- clock / reset / bus ----------------
    logic       pclk  = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       vsync = 1'b0;
    logic       href  = 1'b0;
    logic [7:0] d     = '0;

    logic              we0, fd0, busy0, lerr0, ovf0;
    logic [ADDR_W-1:0] addr0;
    logic [11:0]       dout0;
    logic              we1, fd1, busy1, lerr1, ovf1;
    logic [ADDR_W-1:0] addr1;
    logic [11:0]       dout1;

    always #5 pclk = ~pclk;

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .CONTINUOUS(1)) u_cont (
        .pclk(pclk), .rst_n(rst_n), .start(start), .vsync(vsync), .href(href), .d(d),
        .we(we0), .addr(addr0), .dout(dout0), .frame_done(fd0), .busy(busy0),
        .line_err(lerr0), .overflow(ovf0)
    );

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .CONTINUOUS(0)) u_one (
        .pclk(pclk), .rst_n(rst_n), .start(start), .vsync(vsync), .href(href), .d(d),
        .we(we1), .addr(addr1), .dout(dout1), .frame_done(fd1), .busy(busy1),
        .line_err(lerr1), .overflow(ovf1)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp0_q[$];
    logic [EW-1:0] exp1_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fd0_cnt     = 0;
    int   fd1_cnt     = 0;
    bit   act0 = 1'b0, act1 = 1'b0, armed0 = 1'b1, armed1 = 1'b0;
    int   pix0 = 0, pix1 = 0;
    logic [3:0] cur_r = '0;
    logic prev_we0 = 1'b0, prev_we1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_pixel(input logic [11:0] px);
        if (act0) begin
            if (pix0 < FRAME) exp0_q.push_back({ADDR_W'(pix0), px});
            pix0++;
        end
        if (act1) begin
            if (pix1 < FRAME) exp1_q.push_back({ADDR_W'(pix1), px});
            pix1++;
        end
    endtask

    task automatic idle_cycle();
        @(negedge pclk);
        href = 1'b0;
        d    = 8'($urandom);
    endtask

    task automatic send_byte(input int i);
        logic [3:0] g, b;
        @(negedge pclk);
        href = 1'b1;
        if ((i % 2) == 0) begin
            cur_r = 4'($urandom_range(0, 15));
            d     = {4'hF, cur_r};
        end else begin
            g = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            d = {g, b};
            push_pixel({cur_r, g, b});
        end
    endtask

    task automatic send_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(i);
        repeat (4) idle_cycle();
    endtask

    task automatic pulse_start();
        @(negedge pclk);
        href  = 1'b0;
        start = 1'b1;
        @(negedge pclk);
        start = 1'b0;
        if (!act1) armed1 = 1'b1;
    endtask

    // 3-cycle VSYNC pulse followed by 5 blank cycles; ends one frame, begins the next.
    task automatic vsync_pulse();
        @(negedge pclk);
        vsync = 1'b1;
        href  = 1'b0;
        repeat (2) @(negedge pclk);
        @(negedge pclk);
        vsync  = 1'b0;
        act0   = armed0;
        pix0   = 0;
        act1   = armed1;
        armed1 = 1'b0;
        pix1   = 0;
        repeat (5) idle_cycle();
    endtask

    task automatic send_frame(input int nlines, input int short_line, input int start_line);
        for (int l = 0; l < nlines; l++) begin
            if (l == start_line) pulse_start();
            send_line((l == short_line) ? LINE_BYTES - 1 : LINE_BYTES);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        forever begin
            @(negedge pclk);
            if (!rst_n) begin
                prev_we0 = 1'b0;
                prev_we1 = 1'b0;
            end else begin
                if (fd0) fd0_cnt++;
                if (fd1) fd1_cnt++;
                if (we0) begin
                    check("cont_we_back_to_back", 32'(prev_we0), 32'd0);
                    if (exp0_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL cont_unexpected_write: got addr 0x%0h dout 0x%0h, required no write", addr0, dout0);
                    end else begin
                        e = exp0_q.pop_front();
                        check("cont_addr", 32'(addr0), 32'(e[EW-1:12]));
                        check("cont_dout", 32'(dout0), 32'(e[11:0]));
                    end
                end
                if (we1) begin
                    check("one_we_back_to_back", 32'(prev_we1), 32'd0);
                    if (exp1_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL one_unexpected_write: got addr 0x%0h dout 0x%0h, required no write", addr1, dout1);
                    end else begin
                        e = exp1_q.pop_front();
                        check("one_addr", 32'(addr1), 32'(e[EW-1:12]));
                        check("one_dout", 32'(dout1), 32'(e[11:0]));
                    end
                end
                prev_we0 = we0;
                prev_we1 = we1;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        #2 rst_n = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_we",         32'(we0),   32'd0);
        check("rst_addr",       32'(addr0), 32'd0);
        check("rst_dout",       32'(dout0), 32'd0);
        check("rst_frame_done", 32'(fd0),   32'd0);
        check("rst_busy",       32'(busy0), 32'd0);
        check("rst_line_err",   32'(lerr0), 32'd0);
        check("rst_overflow",   32'(ovf0),  32'd0);
        check("rst_one_busy",   32'(busy1), 32'd0);
        rst_n = 1'b1;
        repeat (3) idle_cycle();
        check("cont_armed_busy", 32'(busy0), 32'd1);
        check("one_idle_busy",   32'(busy1), 32'd0);

        // Frame 1 and 2: clean back-to-back frames.
        vsync_pulse();
        send_frame(V, -1, -1);
        vsync_pulse();
        check("frame1_done_count", 32'(fd0_cnt), 32'd1);
        check("frame1_line_err",   32'(lerr0),   32'd0);
        check("frame1_overflow",   32'(ovf0),    32'd0);
        send_frame(V, -1, -1);
        vsync_pulse();
        check("frame2_done_count", 32'(fd0_cnt), 32'd2);
        check("frame2_line_err",   32'(lerr0),   32'd0);
        check("frame2_overflow",   32'(ovf0),    32'd0);

        // Frame 3: line 1 is one byte short.
        send_frame(V, 1, -1);
        vsync_pulse();
        check("short_line_err",  32'(lerr0), 32'd1);
        check("short_overflow",  32'(ovf0),  32'd0);

        // Frame 4: clean frame, line_err must stay set.
        send_frame(V, -1, -1);
        vsync_pulse();
        check("line_err_sticky", 32'(lerr0), 32'd1);

        // Frame 5: one line too many.
        send_frame(V + 1, -1, -1);
        vsync_pulse();
        check("extra_line_overflow", 32'(ovf0), 32'd1);
        check("frame5_done_count",   32'(fd0_cnt), 32'd5);

        // Frame 6: start u_one mid-frame; it must wait for the next VSYNC.
        send_frame(V, -1, 1);
        vsync_pulse();
        check("one_busy_after_start", 32'(busy1),   32'd1);
        check("one_no_done_yet",      32'(fd1_cnt), 32'd0);

        // Frame 7: both instances capture.
        send_frame(V, -1, -1);
        vsync_pulse();
        check("one_done_count",  32'(fd1_cnt), 32'd1);
        check("one_idle_after",  32'(busy1),   32'd0);
        check("one_line_err",    32'(lerr1),   32'd0);
        check("one_overflow",    32'(ovf1),    32'd0);

        // Frame 8: u_one stays idle.
        send_frame(V, -1, -1);
        vsync_pulse();
        check("one_done_still_1", 32'(fd1_cnt), 32'd1);
        check("frame8_done_count", 32'(fd0_cnt), 32'd8);

        // Frame 9: reset in the middle of line 0.
        send_byte(0);
        send_byte(1);
        send_byte(2);
        @(posedge pclk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we",         32'(we0),   32'd0);
        check("midrst_addr",       32'(addr0), 32'd0);
        check("midrst_dout",       32'(dout0), 32'd0);
        check("midrst_frame_done", 32'(fd0),   32'd0);
        check("midrst_busy",       32'(busy0), 32'd0);
        check("midrst_line_err",   32'(lerr0), 32'd0);
        check("midrst_overflow",   32'(ovf0),  32'd0);
        act0   = 1'b0;
        act1   = 1'b0;
        armed1 = 1'b0;
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        for (int i = 3; i < LINE_BYTES; i++) send_byte(i);
        repeat (4) idle_cycle();
        send_line(LINE_BYTES);

        // Capture resumes only on the next full frame, starting at address 0.
        vsync_pulse();
        send_frame(V, -1, -1);
        vsync_pulse();
        check("resume_done_count", 32'(fd0_cnt), 32'd9);
        check("resume_line_err",   32'(lerr0),   32'd0);
        check("resume_overflow",   32'(ovf0),    32'd0);

        repeat (5) idle_cycle();
        check("cont_queue_drained", 32'(exp0_q.size()), 32'd0);
        check("one_queue_drained",  32'(exp1_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Captures RGB444 pixel data from the OV7670 camera byte bus and writes one 12-bit pixel per two PCLK bytes into the frame BRAM write port. It sits between the camera pins (VSYNC/HREF/D) and the dual-port frame buffer that the VGA side reads. It also frames the capture, checks line lengths, and guards the BRAM address range.

## Interface
- H_PIXELS, 640: pixels per line (HREF-high window = 2*H_PIXELS bytes).
- V_LINES, 480: lines per frame.
- CONTINUOUS, 1: 1 = re-arm automatically after every frame; 0 = capture one frame per `start`.
- pclk  in  1  camera pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  arm request (single-cycle pulse, synchronous to pclk); ignored unless idle.
- vsync  in  1  camera VSYNC, high = vertical blank/frame boundary.
- href  in  1  camera HREF, high = valid bytes on `d`.
- d  in  8  camera data byte.
- we  out  1  BRAM write enable, one cycle per pixel.
- addr  out  19  BRAM write address, 0..H_PIXELS*V_LINES-1.
- dout  out  12  pixel {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse at end of captured frame.
- busy  out  1  high in any state other than IDLE.
- line_err  out  1  sticky: a line had a byte count other than 2*H_PIXELS.
- overflow  out  1  sticky: pixels or lines beyond frame budget were dropped.

## Operation
- States: IDLE, ARM, VBLANK, ACTIVE.
- IDLE: CONTINUOUS=1 goes to ARM the cycle after reset release; else ARM on `start`.
- ARM: wait for sampled vsync=1 -> VBLANK (guarantees capture starts at a frame boundary, never mid-frame).
- VBLANK: on vsync=0 -> ACTIVE; clear pixel counter, line counter, byte phase.
- ACTIVE, href=1: byte phase toggles each cycle. Phase 0 latches d[3:0] as R (d[7:4] discarded). Phase 1 forms {R, d[7:0]} and issues a write.
- ACTIVE, href falling (1 then 0): compare the line byte count to 2*H_PIXELS; a mismatch sets line_err. A trailing phase-0 byte is discarded. Phase resets to 0; line counter +1.
- ACTIVE, vsync=1: pulse frame_done. Next state is VBLANK if CONTINUOUS=1, else IDLE.
- Address: write uses the current pixel counter, then the counter increments. When the counter equals H_PIXELS*V_LINES, further pixels are not written (we stays 0) and overflow is set. Lines beyond V_LINES also set overflow.
- href ignored outside ACTIVE; `start` ignored outside IDLE.
- line_err/overflow clear only on reset or on `start` accepted in IDLE.

## Timing
- Reset values: we=0, addr=0, dout=0, frame_done=0, busy=0, line_err=0, overflow=0, state IDLE.
- Inputs are sampled on the rising pclk edge. The camera changes them on the falling edge, so no synchronizer is needed.
- Write latency: the phase-1 byte is sampled at edge k; we/addr/dout are registered at edge k and valid for exactly the cycle after it. we is never high two cycles in a row.
- frame_done: registered at the edge where vsync=1 is first sampled in ACTIVE; high for one cycle.
- Full frame: exactly H_PIXELS*V_LINES writes, addresses 0..307199 (default) in order, no gaps.
- Edge cases:
  - href and vsync high in the same cycle in ACTIVE: vsync wins. The pending phase-0 byte is dropped and the line check is skipped.
  - Reset mid-frame: everything returns to reset values immediately; capture resumes only after the next full vsync pulse.

## Structure
- Package cam_capture_pkg:
  - state enum `cap_state_t`.
  - ADDR_W=19.
  - function frame_pixels(H,V).
  - RGB444 pixel typedef `rgb444_t`.
- Sub-module cam_pixel_packer:
  - holds the byte phase, the R latch and the line byte counter.
  - outputs `pix_valid`/`pix`/`line_end`/`line_bad`.
- Top-level FSM, address counter, line counter and sticky flags live in ov7670_capture.

## Test plan
- Reset, CONTINUOUS=1, 3-line vsync then 17-line blank, 480 lines x 1280 bytes (d = {4'hF,R} then {G,B}, random) -> 307200 writes, addr 0..307199 in order, dout matches a scoreboard queue, one frame_done.
- Second frame back-to-back -> addresses restart at 0; line_err=0, overflow=0.
- Line of 1279 bytes -> last half pixel dropped, 639 writes for that line, line_err=1 and sticky.
- 481 lines -> writes stop after addr 307199, overflow=1, no write at addr 307200.
- CONTINUOUS=0: start pulse while vsync low mid-frame -> no writes until the next vsync high then low; after frame_done, busy=0 and no further writes.
- rst_n low for 2 cycles mid-line -> all outputs 0 at once; capture resumes at the next frame, first write addr=0.
